// File: rtl/uart_tx_arbiter_if.sv
// Producer-side byte streams and uart_tx start/busy/done handshake shared by the arbiter.
// The master modport is the environment (producers plus uart_tx); the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_start;
    logic [7:0]           tx_din;

    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, tx_start, tx_din
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, tx_start, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Optional HOLD lock timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int HOLD_TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic [1:0]       grant_id,
    output logic             grant_valid,
    output logic             timeout_flag
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || HOLD_TIMEOUT < 2) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..4 and HOLD_TIMEOUT at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

    state_t     state;
    logic       last_reg;
    logic       locked;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic [7:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = bus.req_data[8*g +: 8];
    end

    // grant_id doubles as the round-robin pointer: both update only at grant time.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        winner = grant_id;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((int'(grant_id) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_TIMEOUT);
    logic [CNT_W-1:0] hold_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_din    <= '0;
            grant_id      <= LAST_ID;
            grant_valid   <= 1'b0;
            last_reg      <= 1'b0;
            locked        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_flag  <= 1'b0;
            hold_cnt      <= '0;
`endif
        end else begin
            bus.tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found && !bus.tx_busy) begin
                        grant_id      <= winner;
                        grant_valid   <= 1'b1;
                        bus.req_ready <= NUM_REQ'(1) << winner;
                        state         <= LOAD;
                    end
                end

                LOAD: begin
                    bus.req_ready <= '0;
                    if (bus.req_valid[grant_id]) begin
                        bus.tx_din   <= req_bytes[grant_id];
                        last_reg     <= bus.req_last[grant_id];
                        bus.tx_start <= 1'b1;
                        state        <= WAIT_BUSY;
                    end else if (locked) begin
                        state <= HOLD;
                    end else begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end

                // A done pulse that beats the busy flag still counts as completion.
                WAIT_BUSY, WAIT_DONE: begin
                    if (bus.tx_done) begin
                        if (last_reg) begin
                            grant_valid <= 1'b0;
                            locked      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            locked <= 1'b1;
                            state  <= HOLD;
                        end
                    end else if (state == WAIT_BUSY && bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end

                HOLD: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
                        hold_cnt     <= '0;
                        grant_valid  <= 1'b0;
                        timeout_flag <= 1'b1;
                        locked       <= 1'b0;
                        state        <= IDLE;
                    end else if (bus.req_valid[grant_id]) begin
                        hold_cnt      <= '0;
                        bus.req_ready <= NUM_REQ'(1) << grant_id;
                        state         <= LOAD;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`else
                    if (bus.req_valid[grant_id]) begin
                        bus.req_ready <= NUM_REQ'(1) << grant_id;
                        state         <= LOAD;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven producers, a behavioural uart_tx,
// and a packet-level round-robin model predicting wire byte order and grant order.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 3;
    localparam int HOLD_TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout_flag;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout_flag(timeout_flag)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t              src_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] pop_pending;
    logic [7:0]         wire_q[$];
    int                 grant_q[$];
    logic [7:0]         exp_wire[$];
    int                 exp_grant[$];
    logic               uart_busy, uart_done, ext_busy, prev_gv;
    int                 uart_cnt;
    int                 frame_len = 4;
    logic [7:0]         frame_byte;

    assign bus.tx_busy = uart_busy | ext_busy;
    assign bus.tx_done = uart_done;

    task automatic clear_models();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        wire_q.delete();
        grant_q.delete();
        exp_wire.delete();
        exp_grant.delete();
        pop_pending   = '0;
        uart_busy     = 1'b0;
        uart_done     = 1'b0;
        ext_busy      = 1'b0;
        uart_cnt      = 0;
        prev_gv       = 1'b0;
        frame_byte    = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    endtask

    task automatic push(input int id, input logic [7:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[id].push_back(b);
    endtask

    // One clock of environment: monitors, producer queues, behavioural uart_tx.
    task automatic tick();
        logic [NUM_REQ-1:0]   v;
        logic [8*NUM_REQ-1:0] d;
        logic [NUM_REQ-1:0]   l;
        @(negedge clk);
        tests_run++;
        if ($countones(bus.req_ready) > 1) begin
            tests_failed++;
            $display("FAIL ready_onehot: got %b, required at most one bit set", bus.req_ready);
        end
        tests_run++;
        if (bus.tx_start && bus.tx_busy) begin
            tests_failed++;
            $display("FAIL start_while_busy: got tx_start=1 with tx_busy=1, required no start");
        end
        if (uart_busy) begin
            tests_run++;
            if (bus.tx_din !== frame_byte) begin
                tests_failed++;
                $display("FAIL din_stable: got %h, required %h", bus.tx_din, frame_byte);
            end
        end
`ifndef UART_ARB_TIMEOUT_EN
        tests_run++;
        if (timeout_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_tied: got %b, required 0", timeout_flag);
        end
`endif
        if (grant_valid && !prev_gv) grant_q.push_back(int'(grant_id));
        prev_gv = grant_valid;

        for (int i = 0; i < NUM_REQ; i++)
            if (pop_pending[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        pop_pending = '0;
        v = '0; d = '0; l = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                v[i]         = 1'b1;
                d[8*i +: 8]  = src_q[i][0].data;
                l[i]         = src_q[i][0].last;
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ready[i] && v[i]) pop_pending[i] = 1'b1;

        uart_done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                uart_busy = 1'b0;
                uart_done = 1'b1;
            end
        end
        if (bus.tx_start) begin
            wire_q.push_back(bus.tx_din);
            frame_byte = bus.tx_din;
            uart_busy  = 1'b1;
            uart_cnt   = frame_len;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_models();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_until_idle(input int budget, output bit ok);
        bit empty;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            empty = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) empty = 1'b0;
            if (empty && pop_pending == '0 && !uart_busy && !uart_done && !grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_models();
        @(negedge clk);
        tests_run += 6;
        if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL rst_ready: got %b, required 0", bus.req_ready); end
        if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL rst_start: got %b, required 0", bus.tx_start); end
        if (bus.tx_din !== 8'h00) begin tests_failed++; $display("FAIL rst_din: got %h, required 00", bus.tx_din); end
        if (grant_id !== 2'(NUM_REQ - 1)) begin tests_failed++; $display("FAIL rst_grant_id: got %0d, required %0d", grant_id, NUM_REQ - 1); end
        if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_grant_valid: got %b, required 0", grant_valid); end
        if (timeout_flag !== 1'b0) begin tests_failed++; $display("FAIL rst_timeout: got %b, required 0", timeout_flag); end
        #1 rst = 1'b1;
    endtask

    task automatic test_single_byte();
        bit ok;
        do_reset();
        push(0, 8'h41, 1'b1);
        tick();
        tick();
        tests_run += 2;
        if (bus.req_ready !== 3'b001) begin tests_failed++; $display("FAIL single_ready: got %b, required 001", bus.req_ready); end
        if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL single_early_start: got %b, required 0", bus.tx_start); end
        tick();
        tests_run += 4;
        if (bus.tx_start !== 1'b1) begin tests_failed++; $display("FAIL single_start: got %b, required 1", bus.tx_start); end
        if (bus.tx_din !== 8'h41) begin tests_failed++; $display("FAIL single_din: got %h, required 41", bus.tx_din); end
        if (bus.req_ready !== 3'b000) begin tests_failed++; $display("FAIL single_ready_drop: got %b, required 000", bus.req_ready); end
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            tests_failed++; $display("FAIL single_grant: got valid=%b id=%0d, required valid=1 id=0", grant_valid, grant_id);
        end
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            tick();
            if (uart_done) ok = 1'b1;
        end
        tests_run += 2;
        if (!ok) begin tests_failed++; $display("FAIL single_done_wait: got no tx_done, required one within 50 cycles"); end
        if (grant_valid !== 1'b1) begin tests_failed++; $display("FAIL single_gv_before_done: got %b, required 1", grant_valid); end
        tick();
        tests_run += 2;
        if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL single_release: got %b, required 0", grant_valid); end
        if (wire_q.size() != 1 || wire_q[0] !== 8'h41) begin
            tests_failed++; $display("FAIL single_wire: got %0d bytes first %h, required 1 byte 41", wire_q.size(), wire_q.size() ? wire_q[0] : 8'h00);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        push(0, 8'h30, 1'b1);
        push(1, 8'h31, 1'b1);
        push(2, 8'h32, 1'b1);
        exp_wire  = {8'h30, 8'h31, 8'h32};
        exp_grant = {0, 1, 2};
        run_until_idle(500, ok);
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL rr_idle: got no idle, required idle within 500 cycles"); end
        if (wire_q.size() != exp_wire.size()) begin tests_failed++; $display("FAIL rr_wire_len: got %0d, required %0d", wire_q.size(), exp_wire.size()); end
        else foreach (exp_wire[k]) begin
            tests_run++;
            if (wire_q[k] !== exp_wire[k]) begin tests_failed++; $display("FAIL rr_wire[%0d]: got %h, required %h", k, wire_q[k], exp_wire[k]); end
        end
        if (grant_q.size() != exp_grant.size()) begin tests_failed++; $display("FAIL rr_grant_len: got %0d, required %0d", grant_q.size(), exp_grant.size()); end
        else foreach (exp_grant[k]) begin
            tests_run++;
            if (grant_q[k] != exp_grant[k]) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %0d, required %0d", k, grant_q[k], exp_grant[k]); end
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        do_reset();
        push(1, "1", 1'b0);
        push(1, "2", 1'b0);
        push(1, ":", 1'b0);
        push(1, "3", 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (grant_valid) ok = 1'b1;
        end
        tests_run++;
        if (!ok || grant_id !== 2'd1) begin tests_failed++; $display("FAIL lock_first_grant: got valid=%b id=%0d, required valid=1 id=1", ok, grant_id); end
        push(0, "A", 1'b1);
        exp_wire  = {"1", "2", ":", "3", "A"};
        exp_grant = {1, 0};
        run_until_idle(500, ok);
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL lock_idle: got no idle, required idle within 500 cycles"); end
        if (wire_q.size() != exp_wire.size()) begin tests_failed++; $display("FAIL lock_wire_len: got %0d, required %0d", wire_q.size(), exp_wire.size()); end
        else foreach (exp_wire[k]) begin
            tests_run++;
            if (wire_q[k] !== exp_wire[k]) begin tests_failed++; $display("FAIL lock_wire[%0d]: got %h, required %h", k, wire_q[k], exp_wire[k]); end
        end
        if (grant_q.size() != exp_grant.size()) begin tests_failed++; $display("FAIL lock_grant_len: got %0d, required %0d", grant_q.size(), exp_grant.size()); end
        else foreach (exp_grant[k]) begin
            tests_run++;
            if (grant_q[k] != exp_grant[k]) begin tests_failed++; $display("FAIL lock_grant[%0d]: got %0d, required %0d", k, grant_q[k], exp_grant[k]); end
        end
    endtask

    task automatic test_external_busy();
        bit ok;
        do_reset();
        ext_busy = 1'b1;
        push(0, 8'h5A, 1'b1);
        repeat (8) begin
            tick();
            tests_run++;
            if (bus.req_ready !== '0 || bus.tx_start !== 1'b0) begin
                tests_failed++; $display("FAIL busy_hold: got ready=%b start=%b, required 000/0", bus.req_ready, bus.tx_start);
            end
        end
        ext_busy = 1'b0;
        tick();
        tests_run++;
        if (bus.req_ready !== 3'b001) begin tests_failed++; $display("FAIL busy_ready: got %b, required 001", bus.req_ready); end
        tick();
        tests_run++;
        if (bus.tx_start !== 1'b1 || bus.tx_din !== 8'h5A) begin
            tests_failed++; $display("FAIL busy_launch: got start=%b din=%h, required 1/5a", bus.tx_start, bus.tx_din);
        end
        run_until_idle(200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL busy_idle: got no idle, required idle within 200 cycles"); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        do_reset();
        push(1, 8'h77, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (uart_busy && uart_cnt < frame_len) ok = 1'b1;
        end
        #1 rst = 1'b0;
        #1;
        tests_run += 4;
        if (!ok) begin tests_failed++; $display("FAIL midrst_reach: got no frame in flight, required one"); end
        if (bus.req_ready !== '0 || bus.tx_start !== 1'b0 || bus.tx_din !== 8'h00) begin
            tests_failed++; $display("FAIL midrst_bus: got ready=%b start=%b din=%h, required 000/0/00", bus.req_ready, bus.tx_start, bus.tx_din);
        end
        if (grant_valid !== 1'b0 || grant_id !== 2'(NUM_REQ - 1)) begin
            tests_failed++; $display("FAIL midrst_grant: got valid=%b id=%0d, required 0/%0d", grant_valid, grant_id, NUM_REQ - 1);
        end
        if (timeout_flag !== 1'b0) begin tests_failed++; $display("FAIL midrst_timeout: got %b, required 0", timeout_flag); end
        clear_models();
        push(1, 8'h66, 1'b1);
        push(0, 8'h55, 1'b1);
        #1 rst = 1'b1;
        exp_wire  = {8'h55, 8'h66};
        exp_grant = {0, 1};
        run_until_idle(300, ok);
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL midrst_idle: got no idle, required idle within 300 cycles"); end
        if (wire_q.size() != 2 || wire_q[0] !== exp_wire[0] || wire_q[1] !== exp_wire[1]) begin
            tests_failed++; $display("FAIL midrst_wire: got %0d bytes, first %h, required 55 then 66", wire_q.size(), wire_q.size() ? wire_q[0] : 8'h00);
        end
        if (grant_q.size() != 2 || grant_q[0] != exp_grant[0] || grant_q[1] != exp_grant[1]) begin
            tests_failed++; $display("FAIL midrst_grant_order: got %0d grants, first %0d, required 0 then 1", grant_q.size(), grant_q.size() ? grant_q[0] : -1);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int n;
        do_reset();
        push(2, 8'h20, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (grant_valid) ok = 1'b1;
        end
        tests_run++;
        if (!ok || grant_id !== 2'd2) begin tests_failed++; $display("FAIL hold_grant: got valid=%b id=%0d, required 1/2", ok, grant_id); end
        push(0, 8'h0A, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            tick();
            if (uart_done) ok = 1'b1;
        end
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL hold_done_wait: got no tx_done, required one within 50 cycles"); end
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            tick();
            n++;
            if (timeout_flag) ok = 1'b1;
        end
        tests_run += 2;
        if (!ok || n != HOLD_TIMEOUT + 1) begin tests_failed++; $display("FAIL timeout_delay: got %0d cycles, required %0d", n, HOLD_TIMEOUT + 1); end
        if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL timeout_release: got %b, required 0", grant_valid); end
        tick();
        tests_run++;
        if (timeout_flag !== 1'b0) begin tests_failed++; $display("FAIL timeout_pulse: got %b, required 0", timeout_flag); end
        exp_wire = {8'h20, 8'h0A};
`else
        n = 0;
        repeat (40) begin
            tick();
            tests_run++;
            if (bus.req_ready !== '0 || grant_valid !== 1'b1 || grant_id !== 2'd2) begin
                tests_failed++; $display("FAIL hold_wait: got ready=%b valid=%b id=%0d, required 000/1/2", bus.req_ready, grant_valid, grant_id);
            end
        end
        push(2, 8'h21, 1'b1);
        exp_wire = {8'h20, 8'h21, 8'h0A};
`endif
        exp_grant = {2, 0};
        run_until_idle(300, ok);
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL hold_idle: got no idle, required idle within 300 cycles"); end
        if (wire_q.size() != exp_wire.size()) begin tests_failed++; $display("FAIL hold_wire_len: got %0d, required %0d", wire_q.size(), exp_wire.size()); end
        else foreach (exp_wire[k]) begin
            tests_run++;
            if (wire_q[k] !== exp_wire[k]) begin tests_failed++; $display("FAIL hold_wire[%0d]: got %h, required %h", k, wire_q[k], exp_wire[k]); end
        end
        if (grant_q.size() != 2 || grant_q[0] != exp_grant[0] || grant_q[1] != exp_grant[1]) begin
            tests_failed++; $display("FAIL hold_grant_order: got %0d grants, first %0d, required 2 then 0", grant_q.size(), grant_q.size() ? grant_q[0] : -1);
        end
    endtask

    // Random packets queued up front; the model serves whole packets in round-robin order.
    task automatic test_random();
        bit         ok;
        int         plen [NUM_REQ][$];
        logic [7:0] mbytes [NUM_REQ][$];
        int         ptr, len, npk;
        logic [7:0] b;
        bit         more;
        for (int iter = 0; iter < 8; iter++) begin
            do_reset();
            frame_len = $urandom_range(2, 6);
            for (int i = 0; i < NUM_REQ; i++) begin
                plen[i].delete();
                mbytes[i].delete();
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    plen[i].push_back(len);
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom);
                        mbytes[i].push_back(b);
                        push(i, b, j == len - 1);
                    end
                end
            end
            ptr  = NUM_REQ - 1;
            more = 1'b1;
            while (more) begin
                more = 1'b0;
                for (int k = 1; k <= NUM_REQ && !more; k++) begin
                    int c;
                    c = (ptr + k) % NUM_REQ;
                    if (plen[c].size() > 0) begin
                        len = plen[c].pop_front();
                        repeat (len) exp_wire.push_back(mbytes[c].pop_front());
                        exp_grant.push_back(c);
                        ptr  = c;
                        more = 1'b1;
                    end
                end
            end
            run_until_idle(3000, ok);
            tests_run += 3;
            if (!ok) begin tests_failed++; $display("FAIL rand%0d_idle: got no idle, required idle within 3000 cycles", iter); end
            if (wire_q.size() != exp_wire.size()) begin tests_failed++; $display("FAIL rand%0d_wire_len: got %0d, required %0d", iter, wire_q.size(), exp_wire.size()); end
            else foreach (exp_wire[k]) begin
                tests_run++;
                if (wire_q[k] !== exp_wire[k]) begin tests_failed++; $display("FAIL rand%0d_wire[%0d]: got %h, required %h", iter, k, wire_q[k], exp_wire[k]); end
            end
            if (grant_q.size() != exp_grant.size()) begin tests_failed++; $display("FAIL rand%0d_grant_len: got %0d, required %0d", iter, grant_q.size(), exp_grant.size()); end
            else foreach (exp_grant[k]) begin
                tests_run++;
                if (grant_q[k] != exp_grant[k]) begin tests_failed++; $display("FAIL rand%0d_grant[%0d]: got %0d, required %0d", iter, k, grant_q[k], exp_grant[k]); end
            end
        end
        frame_len = 4;
    endtask

    initial begin
        rst = 1'b0;
        clear_models();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_external_busy();
        test_reset_mid_frame();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers, e.g. the clock time reporter, the RX echo path and the alarm/status messenger.
- Round-robin arbitration per packet: a grant is held until the requester's byte flagged last has left the wire.
- Sequences uart_tx by driving its start/din pair and watching its busy/done flags.
- Sits between the producer FIFOs and the uart_tx start/din inputs.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..4.
- HOLD_TIMEOUT, 1_000_000, clk cycles a locked grant may wait for the next byte. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid
- req_ready  out  NUM_REQ  registered one-hot accept pulse
- tx_busy  in  1  uart_tx o_tx_busy
- tx_done  in  1  uart_tx o_tx_done, a 1-cycle pulse
- tx_start  out  1  1-cycle start pulse to uart_tx
- tx_din  out  8  byte to uart_tx, held stable from tx_start until tx_done
- grant_id  out  2  index of the current or last owner
- grant_valid  out  1  high while a requester owns the link (states LOAD..HOLD)
- timeout_flag  out  1  1-cycle pulse on lock timeout; tied 0 without the macro

Behaviour:
- Reset values (rst=0): state IDLE, req_ready=0, tx_start=0, tx_din=0, grant_id=NUM_REQ-1, grant_valid=0, timeout_flag=0, RR pointer=NUM_REQ-1.
- All outputs are registered.
- Round robin: search starts at pointer+1 and wraps modulo NUM_REQ. First requester with req_valid=1 wins. Pointer updates to the winner at grant.
- IDLE: if any req_valid=1 and tx_busy=0:
  - grant_id<=winner, grant_valid<=1, req_ready[winner]<=1, go LOAD.
  - If tx_busy=1, stay IDLE (the link is owned externally).
- LOAD (req_ready[grant_id]=1 this cycle; the handshake completes here):
  - If req_valid[grant_id]=1: data_reg<=req_data byte, last_reg<=req_last bit, tx_din<=byte, tx_start<=1, req_ready<=0, go WAIT_BUSY.
  - If valid has dropped (protocol violation): no capture; go HOLD if a lock is active, otherwise go IDLE.
- WAIT_BUSY: tx_start is forced 0 after its single cycle. Wait for tx_busy=1, then go WAIT_DONE.
  - If tx_done arrives before busy is seen, treat it as done.
- WAIT_DONE: on tx_done=1:
  - If last_reg=1: grant_valid<=0, go IDLE.
  - Otherwise go HOLD; the lock stays active.
- HOLD: when req_valid[grant_id]=1, set req_ready[grant_id]<=1 and go LOAD. Other requesters are ignored even when valid.
- Latency:
  - req_valid sampled in IDLE → req_ready high in the following cycle (1 cycle).
  - Handshake → tx_start high in the next cycle.
  - Best-case IDLE-to-start is 2 cycles.
  - tx_done → next req_ready for a locked packet: 2 cycles (HOLD with valid already high).
- Simultaneous events:
  - tx_done coinciding with new valids is handled by state order; arbitration happens only in IDLE, the cycle after release.
  - A released owner that re-requests loses to any other valid requester (fairness).
- Single-byte packet (req_last=1 on the first byte) releases after that one byte.
- Reset mid-frame: all state clears immediately and asynchronously. uart_tx is reset on the same rst net, so no partial-frame recovery is needed.
- At most one req_ready bit is ever high. tx_start never asserts while tx_busy=1.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A counter runs in HOLD and clears on leaving HOLD.
  - When it reaches HOLD_TIMEOUT-1: grant_valid<=0, timeout_flag<=1 for one cycle, go IDLE. The pointer keeps the timed-out owner.
- Not defined: HOLD waits indefinitely, no counter logic is built, timeout_flag is constant 0.

Test Plan:
- Single requester 0 sends byte 0x41 with last=1 → req_ready[0] 1 cycle after valid; tx_start 2 cycles after valid with tx_din=0x41; grant_valid drops after tx_done; the frame decodes as 0x41.
- Requesters 0, 1 and 2 all valid from reset with single-byte packets 0x30/0x31/0x32 → wire order 0x30, 0x31, 0x32; grant_id sequence 0,1,2.
- Requester 1 sends packet "12:3" (last on '3') while requester 0 is valid throughout → all 4 bytes of requester 1 are sent contiguously; requester 0 is granted only after tx_done of '3'.
- tx_busy held high externally with req_valid[0]=1 → no req_ready and no tx_start until tx_busy=0; then the normal 2-cycle launch.
- rst asserted during WAIT_DONE → all outputs at reset values in the same cycle; after release, a pending requester 0 is granted first.
- UART_ARB_TIMEOUT_EN with HOLD_TIMEOUT=16: requester 2 sends 1 byte with last=0 then goes silent → timeout_flag pulse 16 cycles after entering HOLD; requester 0 is granted next.
